// File: rtl/alu_stim_pkg.sv
// Shared types and constants for the ALU stimulus sequencer: FSM state
// encoding, opcode field sizes, LFSR tap table and a set-bit search helper.
package alu_stim_pkg;

  localparam int SEL_W   = 4;
  localparam int NUM_OPS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Result of searching the opcode mask for a set bit.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } bit_hit_t;

  // Maximal-length Fibonacci tap masks (bit t-1 set for tap t).
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      8:       return 64'h0000_0000_0000_00B8;  // taps 8,6,5,4
      16:      return 64'h0000_0000_0000_D008;  // taps 16,15,13,4
      32:      return 64'h0000_0000_8020_0003;  // taps 32,22,2,1
      default: return 64'hD800_0000_0000_0000;  // taps 64,63,61,60
    endcase
  endfunction

  // Lowest set bit of mask at an index >= lo (lo may be NUM_OPS: no hit).
  function automatic bit_hit_t find_set(input logic [NUM_OPS-1:0] mask,
                                        input logic [SEL_W:0] lo);
    bit_hit_t hit;
    hit.found = 1'b0;
    hit.idx   = '0;
    // Scan downward so the lowest qualifying bit is the one left standing.
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) begin
        hit.found = 1'b1;
        hit.idx   = SEL_W'(i);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/alu_stim_sequencer_if.sv
// Control and vector bus between the stimulus sequencer (master) and its
// user / downstream ALU harness (slave).
interface alu_stim_sequencer_if #(
  parameter int N = 4
);
  logic             start;
  logic             stop;
  logic [2*N-1:0]   seed;
  logic [15:0]      sel_mask;
  logic [N-1:0]     A;
  logic [N-1:0]     B;
  logic [3:0]       Sel;
  logic             vec_valid;
  logic             busy;
  logic             done;
  logic [15:0]      vec_cnt;

  modport master (
    input  start, stop, seed, sel_mask,
    output A, B, Sel, vec_valid, busy, done, vec_cnt
  );

  modport slave (
    output start, stop, seed, sel_mask,
    input  A, B, Sel, vec_valid, busy, done, vec_cnt
  );
endinterface

// File: rtl/alu_stim_gen.sv
// Operand generator: a W-bit register that loads a seed or advances.
// Build option ALU_STIM_EXHAUSTIVE_EN turns the LFSR into an up-counter
// so every operand pair from the seed onward is covered in order.
module alu_stim_gen
  import alu_stim_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         adv,
  input  logic [W-1:0] seed,
  output logic [W-1:0] value
);

`ifdef ALU_STIM_EXHAUSTIVE_EN
  // Counter mode: any seed, including 0, is a valid start point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= seed;
    end else if (adv) begin
      value <= value + W'(1);
    end
  end
`else
  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic feedback;
  assign feedback = ^(value & TAPS);

  // LFSR mode: an all-zero seed would lock up, so it is forced to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= (seed == '0) ? W'(1) : seed;
    end else if (adv) begin
      value <= {value[W-2:0], feedback};
    end
  end
`endif

endmodule

// File: rtl/alu_stim_sequencer.sv
// Stimulus sequencer for the registered ALU harness. Sweeps each opcode
// enabled in sel_mask, issuing NUM_VEC operand pairs per opcode with each
// pair held for HOLD cycles. Every opcode replays the same operand stream.
// Generator type is chosen by ALU_STIM_EXHAUSTIVE_EN (see alu_stim_gen).
module alu_stim_sequencer
  import alu_stim_pkg::*;
#(
  parameter int N       = 4,
  parameter int HOLD    = 2,
  parameter int NUM_VEC = 16
) (
  input logic                  clk,
  input logic                  reset,
  alu_stim_sequencer_if.master bus
);

  localparam int W      = 2 * N;
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int IDX_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_VEC - 1);

  state_t               state_reg, state_next;
  logic [W-1:0]         seed_reg, seed_next;
  logic [NUM_OPS-1:0]   mask_reg, mask_next;
  logic [SEL_W-1:0]     sel_reg, sel_next;
  logic [HOLD_W-1:0]    hold_reg, hold_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [15:0]          cnt_reg, cnt_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 valid_reg, valid_next;
  logic                 gen_load, gen_adv;
  logic [W-1:0]         gen_value;
  bit_hit_t             first_hit, higher_hit;

  assign first_hit  = find_set(mask_reg, '0);
  assign higher_hit = find_set(mask_reg, {1'b0, sel_reg} + (SEL_W + 1)'(1));

  alu_stim_gen #(
    .W (W)
  ) u_gen (
    .clk   (clk),
    .reset (reset),
    .load  (gen_load),
    .adv   (gen_adv),
    .seed  (seed_reg),
    .value (gen_value)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, generator control and next values of all registered outputs.
  always_comb begin
    state_next = state_reg;
    seed_next  = seed_reg;
    mask_next  = mask_reg;
    sel_next   = sel_reg;
    hold_next  = hold_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    valid_next = valid_reg;
    gen_load   = 1'b0;
    gen_adv    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        busy_next  = 1'b0;
        valid_next = 1'b0;
        if (bus.start && !bus.stop) begin
          state_next = ST_LOAD;
          seed_next  = bus.seed;
          mask_next  = bus.sel_mask;
          cnt_next   = '0;
          busy_next  = 1'b1;
        end
      end

      ST_LOAD: begin
        if (bus.stop) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          valid_next = 1'b0;
        end else begin
          gen_load  = 1'b1;
          hold_next = '0;
          idx_next  = '0;
          sel_next  = first_hit.idx;
          if (!first_hit.found) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            valid_next = 1'b0;
          end else begin
            // First vector goes live on this edge, so it is counted now.
            state_next = ST_DRIVE;
            valid_next = 1'b1;
            cnt_next   = cnt_reg + 16'd1;
          end
        end
      end

      ST_DRIVE: begin
        if (bus.stop) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          valid_next = 1'b0;
        end else if (hold_reg != HOLD_LAST) begin
          hold_next = hold_reg + HOLD_W'(1);
        end else begin
          hold_next = '0;
          if (idx_reg != IDX_LAST) begin
            idx_next = idx_reg + IDX_W'(1);
            gen_adv  = 1'b1;
            cnt_next = cnt_reg + 16'd1;
          end else if (higher_hit.found) begin
            // Next opcode restarts the operand stream from the seed.
            idx_next = '0;
            sel_next = higher_hit.idx;
            gen_load = 1'b1;
            cnt_next = cnt_reg + 16'd1;
          end else begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            valid_next = 1'b0;
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
        valid_next = 1'b0;
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_reg  <= '0;
      mask_reg  <= '0;
      sel_reg   <= '0;
      hold_reg  <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      seed_reg  <= seed_next;
      mask_reg  <= mask_next;
      sel_reg   <= sel_next;
      hold_reg  <= hold_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.A         = gen_value[N-1:0];
  assign bus.B         = gen_value[W-1:N];
  assign bus.Sel       = sel_reg;
  assign bus.vec_valid = valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.vec_cnt   = cnt_reg;

endmodule

// File: tb/tb_alu_stim_sequencer.sv
// Directed bench for alu_stim_sequencer: N=4, NUM_VEC=4, one instance with
// HOLD=1 and one with HOLD=2. Expected operand streams are hand-computed
// for the LFSR (taps 8,6,5,4) or, with ALU_STIM_EXHAUSTIVE_EN, the counter.
module tb_alu_stim_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_stim_sequencer_if #(.N(4)) m_if ();
  alu_stim_sequencer_if #(.N(4)) h_if ();

  alu_stim_sequencer #(.N(4), .HOLD(1), .NUM_VEC(4)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if)
  );

  alu_stim_sequencer #(.N(4), .HOLD(2), .NUM_VEC(4)) dut_h (
    .clk   (clk),
    .reset (reset),
    .bus   (h_if)
  );

  // Expected {B,A} streams.
  logic [7:0] seq_s01 [4];  // seed 8'h01
  logic [7:0] seq_s00 [4];  // seed 8'h00
  logic [7:0] seq_s5a [4];  // seed 8'h5A
  logic [7:0] seq_edge [4]; // generator boundary
  logic [7:0] edge_seed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({m_if.A, m_if.B, m_if.Sel, m_if.vec_valid, m_if.busy, m_if.done, m_if.vec_cnt} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {m_if.A, m_if.B, m_if.Sel, m_if.vec_valid, m_if.busy, m_if.done, m_if.vec_cnt});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (m_if.busy !== 1'b0 || m_if.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", m_if.busy, m_if.done);
    end
  endtask

  task automatic test_single_opcode();
    m_if.seed = 8'h01; m_if.sel_mask = 16'h0001; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    checks++;
    if (m_if.busy !== 1'b1 || m_if.vec_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_start: got busy=%b valid=%b expected 1/0", m_if.busy, m_if.vec_valid);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      $display("single: vec %0d Sel=%0d BA=%h cnt=%0d", j, m_if.Sel, {m_if.B, m_if.A}, m_if.vec_cnt);
      checks++;
      if ({m_if.vec_valid, m_if.Sel, m_if.B, m_if.A, m_if.vec_cnt} !== {1'b1, 4'd0, seq_s01[j], 16'(j + 1)}) begin
        errors++;
        $display("FAIL single_vec%0d: got valid=%b Sel=%0d BA=%h cnt=%0d expected 1/0/%h/%0d",
                 j, m_if.vec_valid, m_if.Sel, {m_if.B, m_if.A}, m_if.vec_cnt, seq_s01[j], j + 1);
      end
    end
    tick();
    checks++;
    if ({m_if.done, m_if.busy, m_if.vec_valid, m_if.vec_cnt} !== {3'b100, 16'd4}) begin
      errors++;
      $display("FAIL single_done: got done=%b busy=%b valid=%b cnt=%0d expected 1/0/0/4",
               m_if.done, m_if.busy, m_if.vec_valid, m_if.vec_cnt);
    end
    tick();
    checks++;
    if (m_if.done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: got done=%b expected 0", m_if.done);
    end
  endtask

  task automatic test_multi_opcode();
    logic [3:0] exp_sel [3];
    int busy_cycles;
    exp_sel = '{4'd0, 4'd2, 4'd15};
    m_if.seed = 8'h5A; m_if.sel_mask = 16'h8005; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    busy_cycles = m_if.busy ? 1 : 0;
    for (int o = 0; o < 3; o++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        if (m_if.busy) busy_cycles++;
        $display("multi: op %0d vec %0d Sel=%0d BA=%h", o, j, m_if.Sel, {m_if.B, m_if.A});
        checks++;
        if ({m_if.vec_valid, m_if.Sel, m_if.B, m_if.A} !== {1'b1, exp_sel[o], seq_s5a[j]}) begin
          errors++;
          $display("FAIL multi_vec o%0d j%0d: got valid=%b Sel=%0d BA=%h expected 1/%0d/%h",
                   o, j, m_if.vec_valid, m_if.Sel, {m_if.B, m_if.A}, exp_sel[o], seq_s5a[j]);
        end
      end
    end
    tick();
    if (m_if.busy) busy_cycles++;
    checks++;
    if (m_if.done !== 1'b1 || m_if.vec_cnt !== 16'd12) begin
      errors++;
      $display("FAIL multi_done: got done=%b cnt=%0d expected 1/12", m_if.done, m_if.vec_cnt);
    end
    checks++;
    if (busy_cycles !== 13) begin
      errors++;
      $display("FAIL multi_busy_cycles: got %0d expected 13", busy_cycles);
    end
    tick();
  endtask

  task automatic test_empty_mask_zero_seed();
    int valid_seen = 0;
    m_if.seed = 8'h33; m_if.sel_mask = 16'h0000; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    if (m_if.vec_valid) valid_seen++;
    tick();
    if (m_if.vec_valid) valid_seen++;
    checks++;
    if ({m_if.done, m_if.busy} !== 2'b10) begin
      errors++;
      $display("FAIL empty_done: got done=%b busy=%b expected 1/0", m_if.done, m_if.busy);
    end
    tick();
    if (m_if.vec_valid) valid_seen++;
    checks++;
    if (valid_seen !== 0 || m_if.done !== 1'b0) begin
      errors++;
      $display("FAIL empty_no_valid: got valid_seen=%0d done=%b expected 0/0", valid_seen, m_if.done);
    end
    m_if.seed = 8'h00; m_if.sel_mask = 16'h0010; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      $display("zero_seed: vec %0d Sel=%0d BA=%h", j, m_if.Sel, {m_if.B, m_if.A});
      checks++;
      if ({m_if.vec_valid, m_if.Sel, m_if.B, m_if.A} !== {1'b1, 4'd4, seq_s00[j]}) begin
        errors++;
        $display("FAIL zero_seed_vec%0d: got valid=%b Sel=%0d BA=%h expected 1/4/%h",
                 j, m_if.vec_valid, m_if.Sel, {m_if.B, m_if.A}, seq_s00[j]);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_abort_restart();
    m_if.seed = 8'h01; m_if.sel_mask = 16'h0001; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    tick();
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    checks++;
    if ({m_if.busy, m_if.B, m_if.A, m_if.vec_cnt} !== {1'b1, seq_s01[1], 16'd2}) begin
      errors++;
      $display("FAIL abort_start_ignored: got busy=%b BA=%h cnt=%0d expected 1/%h/2",
               m_if.busy, {m_if.B, m_if.A}, m_if.vec_cnt, seq_s01[1]);
    end
    tick();
    checks++;
    if ({m_if.B, m_if.A, m_if.vec_cnt} !== {seq_s01[2], 16'd3}) begin
      errors++;
      $display("FAIL abort_third_vec: got BA=%h cnt=%0d expected %h/3",
               {m_if.B, m_if.A}, m_if.vec_cnt, seq_s01[2]);
    end
    m_if.stop = 1'b1;
    tick();
    m_if.stop = 1'b0;
    $display("abort: busy=%b valid=%b done=%b cnt=%0d", m_if.busy, m_if.vec_valid, m_if.done, m_if.vec_cnt);
    checks++;
    if ({m_if.busy, m_if.vec_valid, m_if.done, m_if.vec_cnt} !== {3'b000, 16'd3}) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b valid=%b done=%b cnt=%0d expected 0/0/0/3",
               m_if.busy, m_if.vec_valid, m_if.done, m_if.vec_cnt);
    end
    tick();
    checks++;
    if (m_if.busy !== 1'b0 || m_if.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got busy=%b done=%b expected 0/0", m_if.busy, m_if.done);
    end
    m_if.start = 1'b1; m_if.stop = 1'b1;
    tick();
    m_if.start = 1'b0; m_if.stop = 1'b0;
    tick();
    checks++;
    if (m_if.busy !== 1'b0 || m_if.vec_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_beats_start: got busy=%b valid=%b expected 0/0", m_if.busy, m_if.vec_valid);
    end
  endtask

  task automatic test_generator_boundary();
    m_if.seed = edge_seed; m_if.sel_mask = 16'h0002; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      $display("boundary: vec %0d BA=%h", j, {m_if.B, m_if.A});
      checks++;
      if ({m_if.Sel, m_if.B, m_if.A} !== {4'd1, seq_edge[j]}) begin
        errors++;
        $display("FAIL boundary_vec%0d: got Sel=%0d BA=%h expected 1/%h",
                 j, m_if.Sel, {m_if.B, m_if.A}, seq_edge[j]);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_reset_midrun();
    h_if.seed = 8'h01; h_if.sel_mask = 16'h0003; h_if.start = 1'b1;
    tick();
    h_if.start = 1'b0;
    tick();
    tick();
    checks++;
    if ({h_if.vec_valid, h_if.B, h_if.A, h_if.vec_cnt} !== {1'b1, seq_s01[0], 16'd1}) begin
      errors++;
      $display("FAIL hold_first: got valid=%b BA=%h cnt=%0d expected 1/%h/1",
               h_if.vec_valid, {h_if.B, h_if.A}, h_if.vec_cnt, seq_s01[0]);
    end
    tick();
    checks++;
    if ({h_if.B, h_if.A, h_if.vec_cnt} !== {seq_s01[1], 16'd2}) begin
      errors++;
      $display("FAIL hold_second: got BA=%h cnt=%0d expected %h/2",
               {h_if.B, h_if.A}, h_if.vec_cnt, seq_s01[1]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({h_if.A, h_if.B, h_if.Sel, h_if.vec_valid, h_if.busy, h_if.done, h_if.vec_cnt} !== 31'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %h expected 0",
               {h_if.A, h_if.B, h_if.Sel, h_if.vec_valid, h_if.busy, h_if.done, h_if.vec_cnt});
    end
    #3 reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({h_if.busy, h_if.vec_valid, h_if.done} !== 3'b000) begin
      errors++;
      $display("FAIL midrun_after_release: got busy=%b valid=%b done=%b expected 0/0/0",
               h_if.busy, h_if.vec_valid, h_if.done);
    end
  endtask

  initial begin
`ifdef ALU_STIM_EXHAUSTIVE_EN
    seq_s01  = '{8'h01, 8'h02, 8'h03, 8'h04};
    seq_s00  = '{8'h00, 8'h01, 8'h02, 8'h03};
    seq_s5a  = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    edge_seed = 8'hFE;
    seq_edge = '{8'hFE, 8'hFF, 8'h00, 8'h01};
`else
    seq_s01  = '{8'h01, 8'h02, 8'h04, 8'h08};
    seq_s00  = '{8'h01, 8'h02, 8'h04, 8'h08};
    seq_s5a  = '{8'h5A, 8'hB4, 8'h69, 8'hD2};
    edge_seed = 8'h80;
    seq_edge = '{8'h80, 8'h01, 8'h02, 8'h04};
`endif
    m_if.start = 1'b0; m_if.stop = 1'b0; m_if.seed = '0; m_if.sel_mask = '0;
    h_if.start = 1'b0; h_if.stop = 1'b0; h_if.seed = '0; h_if.sel_mask = '0;

    test_reset();
    test_single_opcode();
    test_multi_opcode();
    test_empty_mask_zero_seed();
    test_abort_restart();
    test_generator_boundary();
    test_reset_midrun();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
